// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for the systolic array: feeds K operand beats, waits out the
// array drain, writes N result rows, pulses done. Optional macro: SEQ_PERF_CNT_EN.
module systolic_tile_sequencer #(
  parameter int N         = 4,
  parameter int K_W       = 8,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_LAT = 2*N+2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [K_W-1:0]    k_len_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] c_base_i,
  output logic              op_rd_en_o,
  output logic [ADDR_W-1:0] a_rd_addr_o,
  output logic [ADDR_W-1:0] b_rd_addr_o,
  output logic              arr_valid_o,
  output logic              arr_last_o,
  output logic              res_wr_en_o,
  output logic [ADDR_W-1:0] res_wr_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       perf_cycles_o
);

  localparam int CNT_W = $clog2(DRAIN_LAT + N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  // Command handshake: a command transfers on start_valid_i & start_ready_o;
  // ready is high only in IDLE, so valid may be held high without effect.
  state_t             state_q, state_d;
  logic [K_W-1:0]     k_len_q;
  logic [ADDR_W-1:0]  a_base_q, b_base_q, c_base_q;
  logic [K_W-1:0]     beat_q;
  logic [CNT_W-1:0]   drain_q;
  logic               arr_valid_q, arr_last_q;
  logic               feed_last;

  always_comb begin
    state_d       = state_q;
    start_ready_o = 1'b0;
    op_rd_en_o    = 1'b0;
    res_wr_en_o   = 1'b0;
    done_o        = 1'b0;
    feed_last     = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) state_d = (k_len_i == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        op_rd_en_o = 1'b1;
        feed_last  = (beat_q == k_len_q - K_W'(1));
        if (feed_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // drain_q is 0 on the arr_last_o cycle, so DRAIN begins DRAIN_LAT later
        if (drain_q == CNT_W'(DRAIN_LAT - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        res_wr_en_o = 1'b1;
        if (drain_q == CNT_W'(DRAIN_LAT + N - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      arr_valid_q <= 1'b0;
      arr_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arr_valid_q <= op_rd_en_o;
      arr_last_q  <= feed_last;
      if (state_q == S_IDLE && start_valid_i) begin
        k_len_q  <= k_len_i;
        a_base_q <= a_base_i;
        b_base_q <= b_base_i;
        c_base_q <= c_base_i;
      end
      beat_q  <= (state_q == S_FEED) ? beat_q + K_W'(1) : '0;
      drain_q <= (state_q == S_FLUSH || state_q == S_DRAIN) ? drain_q + CNT_W'(1) : '0;
    end
  end

  assign a_rd_addr_o   = op_rd_en_o  ? a_base_q + ADDR_W'(beat_q) : '0;
  assign b_rd_addr_o   = op_rd_en_o  ? b_base_q + ADDR_W'(beat_q) : '0;
  assign res_wr_addr_o = res_wr_en_o ? c_base_q + ADDR_W'(drain_q - CNT_W'(DRAIN_LAT)) : '0;
  assign arr_valid_o   = arr_valid_q;
  assign arr_last_o    = arr_last_q;
  assign busy_o        = (state_q != S_IDLE);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                               perf_q <= '0;
    else if (busy_o && perf_q != 32'hFFFFFFFF) perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule
